// File: rtl/addsub_nibble_sequencer.sv
// Sequencer that runs a WIDTH-bit add/subtract through an external 4-bit adder,
// least-significant nibble first, with valid/ready handshakes on both sides.
module addsub_nibble_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
);

  localparam int unsigned N    = WIDTH / 4;
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_bx;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;
  logic             r_overflow;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_a_shift;
  logic [WIDTH-1:0] w_b_shift;

  always_comb begin
    w_a_shift = r_a  >> (4 * r_idx);
    w_b_shift = r_bx >> (4 * r_idx);
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    if (r_state == RUN) begin
      add_a   = w_a_shift[3:0];
      add_b   = w_b_shift[3:0];
      add_cin = r_carry;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_bx        <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= op_a;
            r_bx    <= op_b ^ {WIDTH{sub}};
            r_carry <= sub;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < N; i++) begin
            if (r_idx == IDXW'(i)) r_result[4*i +: 4] <= add_sum;
          end
          r_carry <= add_cout;
          if (r_idx == IDX_LAST) begin
            // Top nibble: operand sign bits come from the captured words, result sign from add_sum.
            r_idx       <= '0;
            r_carry_out <= add_cout;
            r_overflow  <= (r_a[WIDTH-1] == r_bx[WIDTH-1]) && (add_sum[3] != r_a[WIDTH-1]);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_nibble_sequencer.sv
// Directed bench for addsub_nibble_sequencer (WIDTH=8) with a behavioural 4-bit adder.
module tb_addsub_nibble_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry_out;
  logic       overflow;
  logic       busy;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_cin;
  logic [3:0] add_sum;
  logic       add_cout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  addsub_nibble_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .carry_out(carry_out),
    .overflow(overflow), .busy(busy), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );

  // Presents one operation, then waits (bounded) for out_valid; leaves out_ready low.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                       output logic [3:0] a0, output logic [3:0] b0,
                       output logic cin0, output logic cin1, output int cycles);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    a0 = add_a; b0 = add_b; cin0 = add_cin; cin1 = 1'b0;
    in_valid = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 1) cin1 = add_cin;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0; sub = 1'b0;
    #12;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if ({out_valid, busy, carry_out, overflow} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {out_valid, busy, carry_out, overflow}); end
    total++; if (result !== 8'h00) begin bad++; $display("FAIL reset_result got=%h exp=00", result); end
    total++; if ({add_a, add_b, add_cin} !== 9'h0) begin bad++; $display("FAIL reset_adder_ports got=%h exp=000", {add_a, add_b, add_cin}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_overflow();
    logic [3:0] a0, b0; logic c0, c1; int cyc;
    do_op(8'h5A, 8'h33, 1'b0, a0, b0, c0, c1, cyc);
    total++; if ({a0, b0, c0} !== {4'hA, 4'h3, 1'b0}) begin bad++; $display("FAIL add_first_nibble got=%h/%h/%b exp=a/3/0", a0, b0, c0); end
    total++; if (cyc !== 2) begin bad++; $display("FAIL add_latency got=%0d exp=2", cyc); end
    total++; if (result !== 8'h8D) begin bad++; $display("FAIL add_result got=%h exp=8d", result); end
    total++; if ({carry_out, overflow} !== 2'b01) begin bad++; $display("FAIL add_flags got=%b exp=01", {carry_out, overflow}); end
    total++; if (c1 !== 1'b0) begin bad++; $display("FAIL add_cin_pass1 got=%b exp=0", c1); end
    release_out();
    total++; if ({out_valid, in_ready, busy} !== 3'b010) begin bad++; $display("FAIL add_return_idle got=%b exp=010", {out_valid, in_ready, busy}); end
  endtask

  task automatic test_sub();
    logic [3:0] a0, b0; logic c0, c1; int cyc;
    do_op(8'h80, 8'h01, 1'b1, a0, b0, c0, c1, cyc);
    total++; if ({b0, c0} !== {4'hE, 1'b1}) begin bad++; $display("FAIL sub1_first_nibble got=%h/%b exp=e/1", b0, c0); end
    total++; if ({result, carry_out, overflow} !== {8'h7F, 2'b11}) begin bad++; $display("FAIL sub1_result got=%h/%b/%b exp=7f/1/1", result, carry_out, overflow); end
    release_out();
    do_op(8'h10, 8'h20, 1'b1, a0, b0, c0, c1, cyc);
    total++; if ({result, carry_out, overflow} !== {8'hF0, 2'b00}) begin bad++; $display("FAIL sub2_result got=%h/%b/%b exp=f0/0/0", result, carry_out, overflow); end
    total++; if (c1 !== 1'b1) begin bad++; $display("FAIL sub2_cin_pass1 got=%b exp=1", c1); end
    release_out();
    do_op(8'h3C, 8'h00, 1'b1, a0, b0, c0, c1, cyc);
    total++; if ({result, carry_out, overflow} !== {8'h3C, 2'b10}) begin bad++; $display("FAIL sub_zero_result got=%h/%b/%b exp=3c/1/0", result, carry_out, overflow); end
    release_out();
  endtask

  task automatic test_wrap();
    logic [3:0] a0, b0; logic c0, c1; int cyc;
    do_op(8'hFF, 8'h01, 1'b0, a0, b0, c0, c1, cyc);
    total++; if (c1 !== 1'b1) begin bad++; $display("FAIL wrap_cin_pass1 got=%b exp=1", c1); end
    total++; if ({result, carry_out, overflow} !== {8'h00, 2'b10}) begin bad++; $display("FAIL wrap_result got=%h/%b/%b exp=00/1/0", result, carry_out, overflow); end
    release_out();
  endtask

  task automatic test_backpressure();
    logic [3:0] a0, b0; logic c0, c1; int cyc; int unstable;
    do_op(8'h12, 8'h34, 1'b0, a0, b0, c0, c1, cyc);
    unstable = 0;
    op_a = 8'hAA; op_b = 8'h55; sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (result !== 8'h46 || carry_out !== 1'b0 || overflow !== 1'b0 ||
          out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || add_a !== 4'h0) unstable++;
    end
    total++; if (unstable !== 0) begin bad++; $display("FAIL hold_stable got=%0d bad cycles exp=0 (result=%h)", unstable, result); end
    in_valid = 1'b0;
    release_out();
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL hold_release got=%b exp=01", {out_valid, in_ready}); end
    do_op(8'h21, 8'h43, 1'b0, a0, b0, c0, c1, cyc);
    total++; if ({a0, b0} !== 8'h13) begin bad++; $display("FAIL b2b_accept got=%h%h exp=13", a0, b0); end
    total++; if ({result, cyc} !== {8'h64, 32'd2}) begin bad++; $display("FAIL b2b_result got=%h cyc=%0d exp=64 cyc=2", result, cyc); end
    release_out();
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] a0, b0; logic c0, c1; int cyc;
    op_a = 8'hFF; op_b = 8'h01; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if ({busy, add_cin} !== 2'b11) begin bad++; $display("FAIL abort_in_run got=%b exp=11", {busy, add_cin}); end
    rst_n = 1'b0;
    #1;
    total++; if ({in_ready, out_valid, busy, carry_out, overflow, result} !== {5'b10000, 8'h00}) begin bad++; $display("FAIL abort_outputs got=%b/%h exp=10000/00", {in_ready, out_valid, busy, carry_out, overflow}, result); end
    total++; if ({add_a, add_b, add_cin} !== 9'h0) begin bad++; $display("FAIL abort_adder_ports got=%h exp=000", {add_a, add_b, add_cin}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(8'h01, 8'h01, 1'b0, a0, b0, c0, c1, cyc);
    total++; if (c0 !== 1'b0) begin bad++; $display("FAIL post_reset_cin got=%b exp=0", c0); end
    total++; if ({result, carry_out, overflow} !== {8'h02, 2'b00}) begin bad++; $display("FAIL post_reset_result got=%h/%b/%b exp=02/0/0", result, carry_out, overflow); end
    release_out();
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub();
    test_wrap();
    test_backpressure();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
